// File: rtl/se_lookup_pkg.sv
// Shared widths, FSM state constants and the queued lookup entry for se_lookup_arbiter.
package se_lookup_pkg;

  localparam int unsigned MAC_W  = 48;
  localparam int unsigned HASH_W = 10;
  localparam int unsigned PMAP_W = 16;
  localparam int unsigned RES_W  = 16;

  // One-hot encodings kept identical to the legacy state register
  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_ISSUE = 4'b0010;
  localparam logic [3:0] S_WAIT  = 4'b0100;
  localparam logic [3:0] S_RESP  = 4'b1000;

  typedef struct packed {
    logic [MAC_W-1:0]  mac;
    logic [HASH_W-1:0] hash;
    logic              source;
    logic [PMAP_W-1:0] portmap;
  } lookup_entry_t;

endpackage

// File: rtl/se_lookup_arbiter_if.sv
// Requester-side and search-engine-side bus of se_lookup_arbiter; slave = arbiter view.
interface se_lookup_arbiter_if import se_lookup_pkg::*; #(parameter int unsigned NREQ = 4);

  logic [NREQ-1:0]        req_vld;
  logic [NREQ*MAC_W-1:0]  req_mac;
  logic [NREQ*HASH_W-1:0] req_hash;
  logic [NREQ-1:0]        req_source;
  logic [NREQ*PMAP_W-1:0] req_portmap;
  logic [NREQ-1:0]        rsp_ack;
  logic [NREQ-1:0]        rsp_nak;
  logic [RES_W-1:0]       rsp_result;
  logic                   rsp_timeout;
  logic                   se_req;
  logic [MAC_W-1:0]       se_mac;
  logic [HASH_W-1:0]      se_hash;
  logic                   se_source;
  logic [PMAP_W-1:0]      source_portmap;
  logic                   se_ack;
  logic                   se_nak;
  logic [RES_W-1:0]       se_result;

  modport slave (
    input  req_vld, req_mac, req_hash, req_source, req_portmap, se_ack, se_nak, se_result,
    output rsp_ack, rsp_nak, rsp_result, rsp_timeout,
           se_req, se_mac, se_hash, se_source, source_portmap
  );

  modport master (
    output req_vld, req_mac, req_hash, req_source, req_portmap, se_ack, se_nak, se_result,
    input  rsp_ack, rsp_nak, rsp_result, rsp_timeout,
           se_req, se_mac, se_hash, se_source, source_portmap
  );

endinterface

// File: rtl/se_lookup_req_fifo.sv
// Two-entry per-requester lookup queue; a push into a full queue is dropped unless a pop frees a slot that cycle.
module se_lookup_req_fifo import se_lookup_pkg::*; (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  lookup_entry_t din,
  output lookup_entry_t dout,
  output logic          empty,
  output logic          full,
  output logic          drop
);

  lookup_entry_t mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop && !empty;
  assign drop    = push && full && !pop_ok;
  assign push_ok = push && !drop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/se_lookup_arbiter.sv
// Round-robin sharing of one MAC search engine among NREQ front ends, with response routing and timeout.
// Define SE_ARB_STAT_EN to build the saturating per-requester grant/drop counters.
module se_lookup_arbiter import se_lookup_pkg::*; #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 rstn,
  se_lookup_arbiter_if.slave   bus,
  output logic [NREQ-1:0]      ovf_flag,
  output logic [NREQ*16-1:0]   stat_grant_cnt,
  output logic [NREQ*16-1:0]   stat_drop_cnt
);

  localparam int unsigned GW     = $clog2(NREQ);
  localparam logic [7:0]  TO_LIM = 8'(TIMEOUT);

  logic [3:0]       state;
  logic [GW-1:0]    owner;
  logic [GW-1:0]    rr_ptr;
  logic [7:0]       cnt;
  logic             nak_r;
  logic             to_r;
  logic [RES_W-1:0] res_r;
  lookup_entry_t    pay;

  lookup_entry_t    head [NREQ];
  logic [NREQ-1:0]  empty;
  logic [NREQ-1:0]  unused_full;
  logic [NREQ-1:0]  drop;
  logic [NREQ-1:0]  pop;
  logic             grant;
  logic             pick_vld;
  logic [GW-1:0]    pick;

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    lookup_entry_t din;
    assign din = '{mac:     bus.req_mac[MAC_W*i +: MAC_W],
                   hash:    bus.req_hash[HASH_W*i +: HASH_W],
                   source:  bus.req_source[i],
                   portmap: bus.req_portmap[PMAP_W*i +: PMAP_W]};
    assign pop[i] = grant && (pick == GW'(i));
    se_lookup_req_fifo u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (bus.req_vld[i]),
      .pop   (pop[i]),
      .din   (din),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (unused_full[i]),
      .drop  (drop[i])
    );
  end

  // First non-empty queue at or after rr_ptr, wrapping past NREQ-1
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] sel;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = GW'(idx);
      if (!pick_vld && !empty[sel]) begin
        pick_vld = 1'b1;
        pick     = sel;
      end
    end
  end

  assign grant = (state == S_IDLE) && pick_vld;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      nak_r  <= 1'b0;
      to_r   <= 1'b0;
      res_r  <= '0;
      pay    <= '0;
    end else begin
      case (state)
        S_IDLE: if (pick_vld) begin
          owner <= pick;
          pay   <= head[pick];
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (bus.se_ack || bus.se_nak) begin
          nak_r <= bus.se_nak;
          to_r  <= 1'b0;
          res_r <= bus.se_result;
          state <= S_RESP;
        end else if (cnt == TO_LIM) begin
          nak_r <= 1'b1;
          to_r  <= 1'b1;
          res_r <= '0;
          state <= S_RESP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        S_RESP: begin
          rr_ptr <= (owner == GW'(NREQ-1)) ? '0 : owner + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.se_req         = (state == S_ISSUE);
  assign bus.se_mac         = pay.mac;
  assign bus.se_hash        = pay.hash;
  assign bus.se_source      = pay.source;
  assign bus.source_portmap = pay.portmap;
  assign bus.rsp_result     = (state == S_RESP) ? res_r : '0;
  assign bus.rsp_timeout    = (state == S_RESP) && to_r;

  always_comb begin
    bus.rsp_ack = '0;
    bus.rsp_nak = '0;
    if (state == S_RESP) begin
      if (nak_r) bus.rsp_nak[owner] = 1'b1;
      else       bus.rsp_ack[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) ovf_flag <= '0;
    else       ovf_flag <= ovf_flag | drop;
  end

`ifdef SE_ARB_STAT_EN
  logic [15:0] gcnt [NREQ];
  logic [15:0] dcnt [NREQ];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        gcnt[i] <= '0;
        dcnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (pop[i]  && gcnt[i] != '1) gcnt[i] <= gcnt[i] + 16'd1;
        if (drop[i] && dcnt[i] != '1) dcnt[i] <= dcnt[i] + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    assign stat_grant_cnt[16*i +: 16] = gcnt[i];
    assign stat_drop_cnt[16*i +: 16]  = dcnt[i];
  end
`else
  assign stat_grant_cnt = '0;
  assign stat_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_se_lookup_arbiter.sv
// Directed self-checking bench for se_lookup_arbiter (NREQ=4, TIMEOUT=63).
module tb_se_lookup_arbiter;
  import se_lookup_pkg::*;

  localparam int unsigned NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      ovf_flag;
  logic [NREQ*16-1:0]   stat_grant_cnt;
  logic [NREQ*16-1:0]   stat_drop_cnt;
  int                   nvec = 0;
  int                   nerr = 0;
  int                   cyc  = 0;

  se_lookup_arbiter_if #(.NREQ(NREQ)) bus ();

  se_lookup_arbiter #(.NREQ(NREQ), .TIMEOUT(63)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus),
    .ovf_flag       (ovf_flag),
    .stat_grant_cnt (stat_grant_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [47:0] mac, input logic [9:0] hash,
                         input logic src, input logic [15:0] pmap);
    bus.req_vld[i]             = 1'b1;
    bus.req_mac[48*i +: 48]    = mac;
    bus.req_hash[10*i +: 10]   = hash;
    bus.req_source[i]          = src;
    bus.req_portmap[16*i +: 16] = pmap;
  endtask

  task automatic clear_req();
    bus.req_vld = '0;
  endtask

  task automatic wait_se_req(input int maxc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      if (bus.se_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Called in the se_req cycle; returns in the cycle the arbiter responds
  task automatic engine_reply(input bit a, input bit n, input logic [15:0] r);
    step();
    bus.se_ack = a; bus.se_nak = n; bus.se_result = r;
    step();
    bus.se_ack = 1'b0; bus.se_nak = 1'b0; bus.se_result = '0;
  endtask

  task automatic test_reset();
    logic [127:0] all_out;
    rstn = 1'b0;
    repeat (3) step();
    all_out = {bus.se_req, bus.rsp_ack, bus.rsp_nak, bus.rsp_result, bus.rsp_timeout,
               bus.se_mac, bus.se_hash, bus.se_source, bus.source_portmap, ovf_flag};
    nvec++;
    if (all_out !== '0 || stat_grant_cnt !== '0 || stat_drop_cnt !== '0) begin
      nerr++; $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    bit ok;
    int c, prev;
    prev = 0;
    for (int i = 0; i < 4; i++) set_req(i, 48'hA000 + 48'(i), 10'(i), 1'(i), 16'(1 << i));
    step(); clear_req();
    for (int k = 0; k < 4; k++) begin
      wait_se_req(20, ok);
      c = cyc;
      nvec++;
      if (!ok) begin nerr++; $display("FAIL rr_se_req_%0d: got no se_req, expected se_req", k); end
      if (k > 0) begin
        nvec++;
        if (c - prev != 4) begin nerr++; $display("FAIL rr_spacing_%0d: got %0d, expected 4", k, c - prev); end
      end
      nvec++;
      if (bus.se_mac !== 48'hA000 + 48'(k)) begin
        nerr++; $display("FAIL rr_order_%0d: got mac %h, expected %h", k, bus.se_mac, 48'hA000 + 48'(k));
      end
      engine_reply(1'b1, 1'b0, 16'(k));
      nvec++;
      if (bus.rsp_ack !== 4'(1 << k) || bus.rsp_result !== 16'(k)) begin
        nerr++; $display("FAIL rr_rsp_%0d: got ack %b res %h, expected ack %b res %h",
                         k, bus.rsp_ack, bus.rsp_result, 4'(1 << k), 16'(k));
      end
      prev = c;
    end
    // Pointer wrapped to 0, so req 0 goes ahead of req 3
    set_req(3, 48'hB3, 10'h3, 1'b0, 16'h0); set_req(0, 48'hB0, 10'h0, 1'b0, 16'h0);
    step(); clear_req();
    wait_se_req(20, ok);
    nvec++;
    if (!ok || bus.se_mac !== 48'hB0) begin nerr++; $display("FAIL rr_wrap_first: got mac %h, expected b0", bus.se_mac); end
    engine_reply(1'b1, 1'b0, 16'h0);
    wait_se_req(20, ok);
    nvec++;
    if (!ok || bus.se_mac !== 48'hB3) begin nerr++; $display("FAIL rr_wrap_second: got mac %h, expected b3", bus.se_mac); end
    engine_reply(1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_single();
    step();
    set_req(2, 48'h0011_2233_4455, 10'h155, 1'b0, 16'h00F0);
    step(); clear_req();
    nvec++;
    if (bus.se_req !== 1'b0) begin nerr++; $display("FAIL single_early: got se_req %b at t+1, expected 0", bus.se_req); end
    step();
    nvec++;
    if (bus.se_req !== 1'b1) begin nerr++; $display("FAIL single_se_req: got %b at t+2, expected 1", bus.se_req); end
    nvec++;
    if ({bus.se_mac, bus.se_hash, bus.se_source, bus.source_portmap} !==
        {48'h0011_2233_4455, 10'h155, 1'b0, 16'h00F0}) begin
      nerr++; $display("FAIL single_payload: got %h %h %b %h, expected 001122334455 155 0 00f0",
                       bus.se_mac, bus.se_hash, bus.se_source, bus.source_portmap);
    end
    engine_reply(1'b1, 1'b0, 16'h0004);
    nvec++;
    if (bus.rsp_ack !== 4'b0100 || bus.rsp_nak !== 4'b0 || bus.rsp_result !== 16'h0004 || bus.rsp_timeout !== 1'b0) begin
      nerr++; $display("FAIL single_rsp: got ack %b nak %b res %h to %b, expected 0100 0000 0004 0",
                       bus.rsp_ack, bus.rsp_nak, bus.rsp_result, bus.rsp_timeout);
    end
    step();
    nvec++;
    if (bus.rsp_ack !== 4'b0) begin nerr++; $display("FAIL single_rsp_width: got ack %b, expected 0000", bus.rsp_ack); end
  endtask

  task automatic test_overflow();
    bit ok;
    set_req(0, 48'hC0, 10'h0, 1'b0, 16'h0);
    step(); clear_req();
    wait_se_req(20, ok);
    step();
    set_req(1, 48'hD1, 10'h1, 1'b0, 16'h1); step();
    set_req(1, 48'hD2, 10'h2, 1'b1, 16'h2); step();
    set_req(1, 48'hD3, 10'h3, 1'b0, 16'h3); step();
    clear_req();
    nvec++;
    if (ovf_flag !== 4'b0010) begin nerr++; $display("FAIL ovf_flag_set: got %b, expected 0010", ovf_flag); end
    nvec++;
`ifdef SE_ARB_STAT_EN
    if (stat_drop_cnt[31:16] !== 16'd1) begin nerr++; $display("FAIL drop_cnt: got %0d, expected 1", stat_drop_cnt[31:16]); end
`else
    if (stat_drop_cnt !== '0) begin nerr++; $display("FAIL drop_cnt_tied: got %h, expected 0", stat_drop_cnt); end
`endif
    engine_reply(1'b0, 1'b1, 16'h00AA);
    nvec++;
    if (bus.rsp_nak !== 4'b0001 || bus.rsp_result !== 16'h00AA) begin
      nerr++; $display("FAIL ovf_owner_rsp: got nak %b res %h, expected 0001 00aa", bus.rsp_nak, bus.rsp_result);
    end
    // Push into the full queue in the cycle its head is granted: accepted
    step();
    set_req(1, 48'hD4, 10'h4, 1'b0, 16'h4);
    step(); clear_req();
    nvec++;
    if (bus.se_req !== 1'b1 || bus.se_mac !== 48'hD1) begin nerr++; $display("FAIL ovf_first: got req %b mac %h, expected 1 d1", bus.se_req, bus.se_mac); end
    engine_reply(1'b1, 1'b0, 16'h0);
    wait_se_req(20, ok);
    nvec++;
    if (!ok || bus.se_mac !== 48'hD2) begin nerr++; $display("FAIL ovf_second: got mac %h, expected d2", bus.se_mac); end
    engine_reply(1'b1, 1'b0, 16'h0);
    wait_se_req(20, ok);
    nvec++;
    if (!ok || bus.se_mac !== 48'hD4) begin nerr++; $display("FAIL ovf_push_on_pop: got mac %h, expected d4", bus.se_mac); end
    engine_reply(1'b1, 1'b0, 16'h0);
    wait_se_req(20, ok);
    nvec++;
    if (ok) begin nerr++; $display("FAIL ovf_no_extra: got se_req mac %h, expected none", bus.se_mac); end
    nvec++;
`ifdef SE_ARB_STAT_EN
    if (stat_drop_cnt[31:16] !== 16'd1 || stat_grant_cnt[31:16] !== 16'd4) begin
      nerr++; $display("FAIL stat_req1: got drop %0d grant %0d, expected 1 4", stat_drop_cnt[31:16], stat_grant_cnt[31:16]);
    end
`else
    if (stat_grant_cnt !== '0) begin nerr++; $display("FAIL grant_cnt_tied: got %h, expected 0", stat_grant_cnt); end
`endif
  endtask

  task automatic test_timeout();
    bit ok, bad;
    set_req(3, 48'hE3, 10'h3, 1'b0, 16'h0);
    step(); clear_req();
    wait_se_req(20, ok);
    nvec++;
    if (!ok) begin nerr++; $display("FAIL to_se_req: got no se_req, expected se_req"); end
    repeat (64) step();
    nvec++;
    if (bus.rsp_nak !== 4'b0) begin nerr++; $display("FAIL to_early: got nak %b at +64, expected 0000", bus.rsp_nak); end
    step();
    nvec++;
    if (bus.rsp_nak !== 4'b1000 || bus.rsp_timeout !== 1'b1 || bus.rsp_result !== 16'h0 || bus.rsp_ack !== 4'b0) begin
      nerr++; $display("FAIL to_rsp: got nak %b to %b res %h ack %b, expected 1000 1 0000 0000",
                       bus.rsp_nak, bus.rsp_timeout, bus.rsp_result, bus.rsp_ack);
    end
    step();
    bus.se_ack = 1'b1; bus.se_result = 16'h1234;
    step();
    bus.se_ack = 1'b0; bus.se_result = '0;
    bad = 1'b0;
    repeat (4) begin
      if (bus.rsp_ack !== 4'b0 || bus.rsp_nak !== 4'b0 || bus.se_req !== 1'b0) bad = 1'b1;
      step();
    end
    nvec++;
    if (bad) begin nerr++; $display("FAIL to_late_ack: got activity %b, expected 0", bad); end
  endtask

  task automatic test_ack_nak_both();
    bit ok;
    set_req(1, 48'hF1, 10'h1, 1'b1, 16'h0);
    step(); clear_req();
    wait_se_req(20, ok);
    engine_reply(1'b1, 1'b1, 16'h000F);
    nvec++;
    if (!ok || bus.rsp_nak !== 4'b0010 || bus.rsp_ack !== 4'b0 || bus.rsp_result !== 16'h000F || bus.rsp_timeout !== 1'b0) begin
      nerr++; $display("FAIL both_rsp: got nak %b ack %b res %h to %b, expected 0010 0000 000f 0",
                       bus.rsp_nak, bus.rsp_ack, bus.rsp_result, bus.rsp_timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    logic [127:0] all_out;
    set_req(0, 48'h90, 10'h0, 1'b0, 16'h0);
    set_req(2, 48'h92, 10'h2, 1'b0, 16'h0);
    set_req(3, 48'h93, 10'h3, 1'b0, 16'h0);
    step(); clear_req();
    wait_se_req(20, ok);
    step();
    rstn = 1'b0; bus.se_ack = 1'b1; bus.se_result = 16'h5555;
    step();
    all_out = {bus.se_req, bus.rsp_ack, bus.rsp_nak, bus.rsp_result, bus.rsp_timeout,
               bus.se_mac, bus.se_hash, bus.se_source, bus.source_portmap, ovf_flag};
    nvec++;
    if (!ok || all_out !== '0 || stat_grant_cnt !== '0 || stat_drop_cnt !== '0) begin
      nerr++; $display("FAIL midreset_outputs: got %h, expected 0", all_out);
    end
    rstn = 1'b1; bus.se_ack = 1'b0; bus.se_result = '0;
    bad = 1'b0;
    repeat (10) begin
      step();
      if (bus.se_req !== 1'b0 || bus.rsp_ack !== 4'b0 || bus.rsp_nak !== 4'b0) bad = 1'b1;
    end
    nvec++;
    if (bad) begin nerr++; $display("FAIL midreset_quiet: got activity %b, expected 0", bad); end
    set_req(3, 48'h63, 10'h3, 1'b0, 16'h0); set_req(1, 48'h61, 10'h1, 1'b0, 16'h0);
    step(); clear_req();
    wait_se_req(20, ok);
    nvec++;
    if (!ok || bus.se_mac !== 48'h61) begin nerr++; $display("FAIL midreset_rr: got mac %h, expected 61", bus.se_mac); end
    engine_reply(1'b1, 1'b0, 16'h0);
    wait_se_req(20, ok);
    nvec++;
    if (!ok || bus.se_mac !== 48'h63) begin nerr++; $display("FAIL midreset_next: got mac %h, expected 63", bus.se_mac); end
    engine_reply(1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    rstn            = 1'b0;
    bus.req_vld     = '0;
    bus.req_mac     = '0;
    bus.req_hash    = '0;
    bus.req_source  = '0;
    bus.req_portmap = '0;
    bus.se_ack      = 1'b0;
    bus.se_nak      = 1'b0;
    bus.se_result   = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_timeout();
    test_ack_nak_both();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/se_lookup_arbiter.md
# se_lookup_arbiter

Shares one MAC search engine (hash lookup / learn) between NREQ frame-processing front ends. Each front end emits single-cycle lookup pulses (destination lookup, then source learn) carrying MAC, hash, source flag and source portmap. The arbiter queues up to two pulses per requester and issues them one at a time to the engine in round-robin order. It routes each ack/nak and result back to the requester that owns it, and times out lost responses.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 63, WAIT cycles before a forced nak (1..255)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_vld  in  NREQ  one-cycle lookup pulse per requester
- req_mac  in  NREQ*48  MAC per requester, slice i at [48i+:48]
- req_hash  in  NREQ*10  hash per requester
- req_source  in  NREQ  0 = destination lookup, 1 = source learn
- req_portmap  in  NREQ*16  source portmap per requester
- rsp_ack  out  NREQ  one-cycle ack to the owning requester
- rsp_nak  out  NREQ  one-cycle nak to the owning requester
- rsp_result  out  16  result, valid with rsp_ack/rsp_nak
- rsp_timeout  out  1  high with the rsp_nak produced by a timeout
- se_req  out  1  one-cycle request to the engine
- se_mac / se_hash / se_source / source_portmap  out  48/10/1/16  engine payload, held from se_req until the next grant
- se_ack, se_nak  in  1 each  engine response
- se_result  in  16  engine result
- ovf_flag  out  NREQ  sticky per requester; set when a pulse is dropped; cleared by reset only
- stat_grant_cnt  out  NREQ*16  grants per requester (see Configuration)
- stat_drop_cnt  out  NREQ*16  drops per requester (see Configuration)

## Operation
- Per-requester 2-entry FIFO of {mac, hash, source, portmap}.
  - Push on req_vld. Pop on grant.
  - Push when full and no pop in the same cycle: entry dropped, ovf_flag[i] set.
  - Push when full with a pop in the same cycle: accepted.
- FSM states IDLE, ISSUE, WAIT, RESP. One-hot encoding. Reset state IDLE.
- IDLE: if any FIFO is non-empty, grant the first non-empty requester at or after rr_ptr (wrapping), pop its head into the payload registers, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: se_req=1 for exactly one cycle; load the timeout counter with 0; go to WAIT.
- WAIT:
  - se_nak -> RESP(nak).
  - se_ack alone -> RESP(ack).
  - Both se_ack and se_nak in the same cycle: nak wins.
  - Counter reaches TIMEOUT -> RESP(nak, timeout).
  - Otherwise increment the counter.
- RESP:
  - Drive rsp_ack[g] or rsp_nak[g] for one cycle, with rsp_result = the se_result captured in WAIT (16'h0 on timeout).
  - Set rr_ptr = (g+1) mod NREQ, with wrap at NREQ-1 → 0.
  - Go to IDLE.
- se_ack/se_nak outside WAIT are ignored. A late response after a timeout is discarded.
- Reset mid-transaction: FSM returns to IDLE, FIFOs are emptied, no rsp is generated.
- Reset values: all outputs 0; rr_ptr 0; ovf_flag 0; counters 0.

## Timing
- req_vld at cycle t → entry visible at t+1.
- If the FSM is IDLE at t+1 → grant at t+1, se_req high at t+2, payload valid from t+2.
- Engine response at cycle u (in WAIT) → rsp_ack/rsp_nak at u+1 → IDLE at u+2.
- Back-to-back grants are therefore at least 4 cycles apart. The fastest response is the cycle after se_req.
- Minimum request-to-response latency, uncontended: se_req at t+2, ack at t+3, rsp at t+4.

## Configuration
- SE_ARB_STAT_EN defined: stat_grant_cnt[i] increments on each grant to i. stat_drop_cnt[i] increments on each drop. Both are 16-bit and saturate at 16'hFFFF.
- SE_ARB_STAT_EN undefined: the counter logic is not built and both stat ports are tied to 0. ovf_flag is always present.

## Structure
- Package se_lookup_pkg:
  - widths MAC_W=48, HASH_W=10, PMAP_W=16, RES_W=16
  - the FSM state constants
  - the lookup-entry packed struct
- Sub-module se_lookup_req_fifo: 2-entry FIFO with push/pop, full/empty and a drop output. Instantiated NREQ times via generate.
- The round-robin priority pick stays inline in the top level.

## Test plan
- Single pulse from req 2 (mac 48'h0011_2233_4455, hash 10'h155); engine acks at the cycle after se_req with result 16'h0004 → se_req at t+2 with matching payload; rsp_ack[2]=1 and rsp_result=16'h0004 at t+4.
- Pulses from req 0,1,2,3 in the same cycle, engine acks immediately each time → grant order 0,1,2,3; se_req pulses exactly 4 cycles apart; rr_ptr=0 afterwards.
- Three pulses from req 1 while the engine is stalled → first two are served in order; third is dropped; ovf_flag[1]=1; with the macro defined, stat_drop_cnt[1]=1.
- Engine never responds, TIMEOUT=63 → rsp_nak and rsp_timeout for the owner 65 cycles after se_req, rsp_result=0; an se_ack arriving later is ignored.
- se_ack and se_nak asserted together with result 16'h000F → only rsp_nak for the owner, rsp_result=16'h000F.
- rstn low while in WAIT with queued entries → all outputs 0 next cycle; no rsp; after reset release, nothing is issued until a new req_vld.
